// File: rtl/counter_9316_cascade_pkg.sv
// Shared constants and nibble helpers for the two-slice 9316-style counter cascade.
package counter_9316_cascade_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int CASCADE_N = 2;
  localparam int COUNT_W   = NIBBLE_W * CASCADE_N;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  function automatic nibble_t nibble_inc(input nibble_t v);
    return v + nibble_t'(1);
  endfunction

  // Terminal count of one slice; feeds that slice's carry out.
  function automatic logic nibble_is_terminal(input nibble_t v);
    return v == {NIBBLE_W{1'b1}};
  endfunction

endpackage

// File: rtl/counter_9316_cascade_dm9316_slice.sv
// One 4-bit synchronous counter slice: clear > load > count, all gated by the chip-clock strobe.
// Q updates one clk after a strobed edge; carry out is combinational on ent and terminal count.
module dm9316_slice
  import counter_9316_cascade_pkg::*;
#(
  parameter nibble_t RESET_VALUE = '0
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    ce,
  input  logic    clr_n,
  input  logic    load_n,
  input  logic    enp,
  input  logic    ent,
  input  nibble_t data,
  output nibble_t q,
  output logic    rco
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (ce) begin
      if (!clr_n) begin
        q <= '0;
      end else if (!load_n) begin
        q <= data;
      end else if (enp && ent) begin
        q <= nibble_inc(q);
      end
    end
  end

  // Independent of enp, ce, clr_n and load_n so the cascade sees carry even while paused.
  assign rco = ent && nibble_is_terminal(q);

endmodule

// File: rtl/counter_9316_cascade.sv
// 8-bit counter built from two chained dm9316 slices; low slice carry enables the high slice.
// One-cycle latency from a CE strobe to Q/A/B/C/D; RCO is combinational.
module counter_9316_cascade
  import counter_9316_cascade_pkg::*;
#(
  parameter logic [COUNT_W-1:0] RESET_VALUE = 8'h00
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic               CLR_N,
  input  logic               LOAD_N,
  input  logic               ENP,
  input  logic               ENT,
  input  logic [COUNT_W-1:0] DATA,
  output logic [COUNT_W-1:0] Q,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D,
  output logic               RCO
);

  nibble_t q_lo;
  nibble_t q_hi;
  logic    rco_lo;
  logic    rco_hi;

  dm9316_slice #(
    .RESET_VALUE(RESET_VALUE[NIBBLE_W-1:0])
  ) u_slice_lo (
    .clk    (CLK),
    .reset  (RESET),
    .ce     (CE),
    .clr_n  (CLR_N),
    .load_n (LOAD_N),
    .enp    (ENP),
    .ent    (ENT),
    .data   (DATA[NIBBLE_W-1:0]),
    .q      (q_lo),
    .rco    (rco_lo)
  );

  dm9316_slice #(
    .RESET_VALUE(RESET_VALUE[COUNT_W-1:NIBBLE_W])
  ) u_slice_hi (
    .clk    (CLK),
    .reset  (RESET),
    .ce     (CE),
    .clr_n  (CLR_N),
    .load_n (LOAD_N),
    .enp    (ENP),
    .ent    (rco_lo),
    .data   (DATA[COUNT_W-1:NIBBLE_W]),
    .q      (q_hi),
    .rco    (rco_hi)
  );

  assign Q   = {q_hi, q_lo};
  assign RCO = rco_hi;

  // Decoder selects are straight wires from the low slice, never re-registered.
  assign A = q_lo[0];
  assign B = q_lo[1];
  assign C = q_lo[2];
  assign D = q_lo[3];

endmodule

// File: doc/counter_9316_cascade.md
COUNTER_9316_CASCADE -- requirements
Module: counter_9316_cascade

Interface
REQ-001 The block SHALL have one parameter: RESET_VALUE, default 8'h00, count value loaded by RESET.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-003 Port CLK  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 Port RESET  input  1  synchronous active-high reset.
REQ-005 Port CE  input  1  chip-clock strobe; one high CLK cycle SHALL represent one rising edge of the emulated chip clock.
REQ-006 Port CLR_N  input  1  clear request, active low, sampled only when CE=1.
REQ-007 Port LOAD_N  input  1  parallel load request, active low, sampled only when CE=1.
REQ-008 Port ENP  input  1  count enable P.
REQ-009 Port ENT  input  1  count enable T; also gates RCO.
REQ-010 Port DATA  input  8  parallel load value.
REQ-011 Port Q  output  8  current count.
REQ-012 Port A, B, C, D  output  1 each  Q[0], Q[1], Q[2], Q[3]; these directly drive the select inputs of the downstream 4-to-16 decoder.
REQ-013 Port RCO  output  1  ripple carry out, active high.

Function
REQ-014 On a CLK edge with CE=0 and RESET=0, Q SHALL hold its value.
REQ-015 On a CLK edge with CE=1, the priority SHALL be: CLR_N=0, then LOAD_N=0, then count.
  - CLR_N=0: Q becomes 8'h00.
  - LOAD_N=0: Q becomes DATA.
  - Count: the rules in REQ-016 to REQ-018 apply.
REQ-016 The low nibble SHALL increment by 1 (mod 16) when ENP=1 and ENT=1; otherwise it holds.
REQ-017 The high nibble SHALL increment by 1 (mod 16) when ENP=1, ENT=1 and the low nibble equals 4'hF; otherwise it holds.
REQ-018 The count SHALL wrap from 8'hFF to 8'h00 with no sticky flag.
REQ-019 RCO SHALL be combinational: RCO = ENT AND (Q == 8'hFF). It SHALL be independent of ENP, CE, CLR_N and LOAD_N.
REQ-020 The latency from a CE=1 edge to the updated Q, A, B, C and D SHALL be exactly one CLK cycle.
REQ-021 A, B, C and D SHALL never be decoupled from Q: they change in the same cycle as Q[3:0] and have no extra register stage.
REQ-022 Load SHALL take all 8 bits of DATA in one CE edge, including DATA values 8'hFF and 8'h0F.
REQ-023 If CLR_N=0 and LOAD_N=0 on the same CE edge, the clear SHALL win.
REQ-024 When ENP=0 and ENT=1, Q SHALL hold, and RCO SHALL still assert at 8'hFF.
REQ-025 CLR_N, LOAD_N, ENP and ENT SHALL be ignored on cycles with CE=0.

Reset
REQ-026 RESET=1 at a CLK edge SHALL set Q to RESET_VALUE regardless of CE, CLR_N, LOAD_N and the enables.
REQ-027 RESET SHALL take priority over every other input, including when it arrives mid-count or mid-load.
REQ-028 During RESET, RCO SHALL follow REQ-019 using the reset value of Q (RCO=0 for the default RESET_VALUE).
REQ-029 The first CE edge after RESET deasserts SHALL operate normally from RESET_VALUE.

Structure
REQ-030 A shared package SHALL hold the nibble-width constant (4) and the cascade count (2).
REQ-031 The block SHALL instantiate sub-module dm9316_slice twice.
  - dm9316_slice is a 4-bit synchronous counter with clear, load, ENP, ENT and RCO.
  - The RCO of the low slice SHALL drive the ENT of the high slice.
  - ENP SHALL be common to both slices.
REQ-032 The block SHALL contain no latches and no derived clocks; CE SHALL be used only as an enable.

Verification
REQ-033 Reset: RESET=1 for 2 cycles -> Q=8'h00 and A=B=C=D=0; with RESET_VALUE=8'h5A -> Q=8'h5A.
REQ-034 Count and cascade:
  - Stimulus: load 8'h0E, then ENP=ENT=1 with CE pulsed every 3rd cycle.
  - Required: Q sequence 0E, 0F, 10, 11; Q holds between pulses; {D,C,B,A} tracks Q[3:0].
REQ-035 Wrap and RCO:
  - Stimulus: load 8'hFE, then count.
  - Required: RCO=0 at FE, RCO=1 at FF, then Q=00 with RCO=0.
  - With ENT=0 at FF: RCO=0 and Q holds.
REQ-036 Priority: CE=1 with CLR_N=0, LOAD_N=0, DATA=8'hA5 -> Q=00; next edge with CLR_N=1, LOAD_N=0 -> Q=A5.
REQ-037 CE gating: CLR_N=0 held 5 cycles with CE=0 -> Q unchanged; assert CE for 1 cycle -> Q=00 on the next cycle.
REQ-038 Reset mid-operation: RESET=1 on the same edge as CE=1 with LOAD_N=0 and DATA=8'h33 -> Q=RESET_VALUE, not 8'h33.
